nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl.sv | 117 +++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add stepped one nibble per cycle through a shared
// 4-bit ripple-carry adder; define NIBBLE_ADDER_SUB_EN to add the in_sub subtract mode.
module rippleca (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_s,
   output logic       o_c4
);
   logic [4:0] w_c;
   assign w_c[0] = i_cin;
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
   end
   assign o_c4 = w_c[4];
endmodule

module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
`ifdef NIBBLE_ADDER_SUB_EN
   ,
   input  logic             in_sub
`endif
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state, w_next;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_a, r_b, r_sum;
   logic             r_c, r_cout, r_ovf;
   logic [WIDTH-1:0] w_beff;
   logic             w_cin, w_last, w_c4;
   logic [3:0]       w_s;

`ifdef NIBBLE_ADDER_SUB_EN
   assign w_beff = in_sub ? ~in_b : in_b;
   assign w_cin  = in_sub | in_cin;
`else
   assign w_beff = in_b;
   assign w_cin  = in_cin;
`endif

   assign w_last = (r_idx == IW'(NIB - 1));

   rippleca u_add (
      .i_a  (r_a[4*r_idx +: 4]),
      .i_b  (r_b[4*r_idx +: 4]),
      .i_cin(r_c),
      .o_s  (w_s),
      .o_c4 (w_c4)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && in_valid) begin
            r_a   <= in_a;
            r_b   <= w_beff;
            r_c   <= w_cin;
            r_idx <= '0;
         end else if (r_state == RUN) begin
            r_sum[4*r_idx +: 4] <= w_s;
            r_c                 <= w_c4;
            r_idx               <= r_idx + IW'(1);
            if (w_last) begin
               r_cout <= w_c4;
               r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[3] != r_a[WIDTH-1]);
            end
         end
      end
   end

   always_comb begin
      w_next = r_state;
      if (r_state == IDLE && in_valid) w_next = RUN;
      else if (r_state == RUN && w_last) w_next = DONE;
      else if (r_state == DONE && out_ready) w_next = IDLE;
   end

   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign out_valid = (r_state == DONE);
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;
   assign out_ovf   = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: scoreboard bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;
   localparam int W   = 16;
   localparam int NIB = W / 4;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk = 0, rst_n = 0;
   logic         in_valid = 0, in_cin = 0, out_ready = 1, in_sub = 0;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic         in_ready, out_valid, out_cout, out_ovf, busy;
   logic [W-1:0] out_sum;

   exp_t q[$];
   int   n_cmp = 0, n_bad = 0;
   int   cyc = 0, acc_cyc = 0;
   logic prev_valid = 0;

   nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
      .out_ovf(out_ovf), .busy(busy)
`ifdef NIBBLE_ADDER_SUB_EN
      , .in_sub(in_sub)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      exp_t         e;
      logic [W-1:0] be;
      logic [W:0]   full;
      logic         ci;
      be     = sub ? ~b : b;
      ci     = sub ? 1'b1 : cin;
      full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (a[W-1] == be[W-1]) && (e.sum[W-1] != a[W-1]);
      return e;
   endfunction

   // Monitor: scoreboard pop on output handshake, latency on out_valid rise.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) acc_cyc = cyc + 1;
      if (rst_n && out_valid && !prev_valid) chk("latency_edges", cyc - acc_cyc + 1, NIB + 1);
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) chk("spurious_out_valid", 1, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("sum", out_sum, e.sum);
            chk("cout", out_cout, e.cout);
            chk("ovf", out_ovf, e.ovf);
         end
      end
      prev_valid = out_valid;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input bit push);
      int t = 0;
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1;
      while (!in_ready && t < 40) begin step(); t++; end
      if (!in_ready) chk("accept_timeout", 0, 1);
      if (push) q.push_back(model(a, b, cin, sub));
      step();
      in_valid = 0;
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 60) begin step(); t++; end
      if (q.size() != 0) chk("drain_timeout", q.size(), 0);
   endtask

   task automatic wait_valid();
      int t = 0;
      while (!out_valid && t < 40) begin step(); t++; end
      if (!out_valid) chk("valid_timeout", 0, 1);
   endtask

   initial begin
      logic [W-1:0] held;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sum", out_sum, 0);
      chk("rst_cout_ovf", {out_cout, out_ovf}, 0);
      rst_n = 1;
      step();

      send(16'h1234, 16'h0FFF, 0, 0, 1);
      chk("busy_run", busy, 1);
      wait_valid();
      step();
      chk("valid_one_cycle", out_valid, 0);
      drain();
      chk("sum_holds", out_sum, 16'h2233);
      send(16'hFFFF, 16'h0001, 0, 0, 1);
      send(16'h7FFF, 16'h0000, 1, 0, 1);
      for (int i = 0; i < 6; i++)
         send(W'($urandom), W'($urandom), 1'($urandom), 0, 1);
      drain();

      // backpressure: result held for 3 cycles, new op held off until after handshake
      out_ready = 0;
      send(16'hA5A5, 16'h1111, 1, 0, 1);
      wait_valid();
      held = out_sum;
      in_a = 16'h0003; in_b = 16'h0004; in_cin = 0; in_valid = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_valid", out_valid, 1);
         chk("bp_sum_stable", out_sum, held);
         chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1;
      step();
      chk("bp_idle_after_hs", in_ready, 1);
      chk("bp_busy_after_hs", busy, 0);
      in_valid = 0;
      send(16'h0003, 16'h0004, 0, 0, 1);
      drain();

      // operands change every cycle during RUN
      send(16'h4321, 16'h1111, 0, 0, 1);
      for (int i = 0; i < NIB; i++) begin
         in_a = W'($urandom); in_b = W'($urandom); in_cin = 1;
         step();
      end
      drain();

      // reset in the second RUN cycle discards the operation
      send(16'h0F0F, 16'h0101, 0, 0, 0);
      step();
      rst_n = 0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_sum", out_sum, 0);
      chk("mid_rst_cout_ovf", {out_cout, out_ovf}, 0);
      step();
      rst_n = 1;
      chk("post_rst_in_ready", in_ready, 1);
      for (int i = 0; i < 8; i++) step();
      send(16'h0001, 16'h0001, 0, 0, 1);
      drain();

`ifdef NIBBLE_ADDER_SUB_EN
      send(16'h0005, 16'h0007, 0, 1, 1);
      send(16'h8000, 16'h0001, 0, 1, 1);
      send(16'h1234, 16'h1234, 0, 1, 1);
      drain();
`endif

      for (int i = 0; i < 4; i++) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
